// File: rtl/seg7_bcd_counter_scan_if.sv
// Control and display bundle between the board switches/pins and seg7_bcd_counter_scan.
// The master side drives the controls; the slave side (the counter/scanner) drives the display.
interface seg7_bcd_counter_scan_if #(
  parameter int NUM_DIGITS = 8
);
  logic                      enable;
  logic                      up_down;
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   load_val;
  logic                      blank_lz;
  logic [NUM_DIGITS-1:0]     dp_mask;
  logic [4*NUM_DIGITS-1:0]   count;
  logic                      wrap;
  logic [NUM_DIGITS-1:0]     AN;
  logic [6:0]                cathode;
  logic                      DP;

  modport master (
    output enable, up_down, load, load_val, blank_lz, dp_mask,
    input  count, wrap, AN, cathode, DP
  );

  modport slave (
    input  enable, up_down, load, load_val, blank_lz, dp_mask,
    output count, wrap, AN, cathode, DP
  );
endinterface

// File: rtl/seg7_bcd_counter_scan.sv
// N-digit BCD up/down counter with prescaled tick, parallel load and wrap pulse,
// plus a free-running time-multiplexed 7-segment scanner with leading-zero blanking.
module seg7_bcd_counter_scan #(
  parameter int NUM_DIGITS = 8,
  parameter int COUNT_DIV  = 10_000_000,
  parameter int SCAN_DIV   = 100_000
) (
  input logic                    clk,
  input logic                    reset,
  seg7_bcd_counter_scan_if.slave bus
);

  localparam int W  = 4 * NUM_DIGITS;
  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(COUNT_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]         presc_r;
  logic [SW-1:0]         scan_r;
  logic [IW-1:0]         idx_r;
  logic [W-1:0]          count_r;
  logic                  wrap_r;
  logic [NUM_DIGITS-1:0] an_r;
  logic [6:0]            cathode_r;
  logic                  dp_r;

  logic                  tick_s;
  logic [W-1:0]          step_val_s;
  logic                  step_carry_s;
  logic [3:0]            step_dig_s;
  logic [W-1:0]          load_sat_s;
  logic [NUM_DIGITS-1:0] lz_s;
  logic                  zero_run_s;
  logic                  hit_s;
  logic [NUM_DIGITS-1:0] an_s;
  logic [3:0]            sel_digit_s;
  logic                  sel_blank_s;
  logic                  sel_dp_s;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] seg;
    case (d)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  function automatic logic [3:0] bcd_sat(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  assign tick_s = bus.enable & (presc_r == PRESC_LAST);

  // Prescaler: runs only while enabled, restarts on load or at terminal count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_r <= {PW{1'b0}};
    end else if (bus.load || tick_s) begin
      presc_r <= {PW{1'b0}};
    end else if (bus.enable) begin
      presc_r <= presc_r + PW'(1);
    end else begin
      presc_r <= presc_r;
    end
  end

  // Next count for one tick; the carry/borrow surviving the top digit is the wrap
  always_comb begin
    step_val_s   = {W{1'b0}};
    step_carry_s = 1'b1;
    step_dig_s   = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      step_dig_s = count_r[4*i +: 4];
      if (step_carry_s == 1'b0) begin
        step_val_s[4*i +: 4] = step_dig_s;
      end else if (bus.up_down) begin
        if (step_dig_s == 4'd9) begin
          step_val_s[4*i +: 4] = 4'd0;
        end else begin
          step_val_s[4*i +: 4] = step_dig_s + 4'd1;
          step_carry_s         = 1'b0;
        end
      end else begin
        if (step_dig_s == 4'd0) begin
          step_val_s[4*i +: 4] = 4'd9;
        end else begin
          step_val_s[4*i +: 4] = step_dig_s - 4'd1;
          step_carry_s         = 1'b0;
        end
      end
    end
  end

  // Out-of-range load digits are clamped to 9 so the count always stays valid BCD
  always_comb begin
    load_sat_s = {W{1'b0}};
    for (int i = 0; i < NUM_DIGITS; i++) begin
      load_sat_s[4*i +: 4] = bcd_sat(bus.load_val[4*i +: 4]);
    end
  end

  // Counter and wrap pulse; load takes priority over a coincident tick
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= {W{1'b0}};
      wrap_r  <= 1'b0;
    end else if (bus.load) begin
      count_r <= load_sat_s;
      wrap_r  <= 1'b0;
    end else if (tick_s) begin
      count_r <= step_val_s;
      wrap_r  <= step_carry_s;
    end else begin
      count_r <= count_r;
      wrap_r  <= 1'b0;
    end
  end

  // Scan divider and digit index, free-running regardless of enable
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_r <= {SW{1'b0}};
      idx_r  <= {IW{1'b0}};
    end else if (scan_r == SCAN_LAST) begin
      scan_r <= {SW{1'b0}};
      idx_r  <= (idx_r == IDX_LAST) ? {IW{1'b0}} : idx_r + IW'(1);
    end else begin
      scan_r <= scan_r + SW'(1);
      idx_r  <= idx_r;
    end
  end

  // lz_s[i] marks that digit i and everything above it are zero
  always_comb begin
    lz_s       = {NUM_DIGITS{1'b0}};
    zero_run_s = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run_s = zero_run_s & (count_r[4*i +: 4] == 4'd0);
      lz_s[i]    = zero_run_s;
    end
  end

  // Select the scanned digit, its blanking and DP as one-hot AND-OR muxes
  always_comb begin
    an_s        = {NUM_DIGITS{1'b1}};
    sel_digit_s = 4'd0;
    sel_blank_s = 1'b0;
    sel_dp_s    = 1'b0;
    hit_s       = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      hit_s       = (idx_r == IW'(i));
      an_s[i]     = ~hit_s;
      sel_digit_s = sel_digit_s | (hit_s ? count_r[4*i +: 4] : 4'd0);
      sel_blank_s = sel_blank_s | (hit_s & bus.blank_lz & lz_s[i] & (i > 0));
      sel_dp_s    = sel_dp_s | (hit_s & bus.dp_mask[i]);
    end
  end

  // Registered pin drivers, all active-low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an_r      <= {NUM_DIGITS{1'b1}};
      cathode_r <= 7'h7F;
      dp_r      <= 1'b1;
    end else begin
      an_r      <= an_s;
      cathode_r <= sel_blank_s ? 7'h7F : seg_decode(sel_digit_s);
      dp_r      <= ~sel_dp_s;
    end
  end

  assign bus.count   = count_r;
  assign bus.wrap    = wrap_r;
  assign bus.AN      = an_r;
  assign bus.cathode = cathode_r;
  assign bus.DP      = dp_r;

endmodule
